// File: rtl/id_ex_stage_if.sv
// ID/EX stage signal bundle: decode-side operands, forwarding taps, stage
// controls, and the registered EX-side results plus the load-use hazard flag.
interface id_ex_stage_if;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [15:0] id_imm16;
  logic [31:0] id_busA;
  logic [31:0] id_busB;
  logic        exf_regwr;
  logic [4:0]  exf_rd;
  logic [31:0] exf_data;
  logic        memf_regwr;
  logic [4:0]  memf_rd;
  logic [31:0] memf_data;
  logic        ex_valid;
  logic [31:0] ex_busA;
  logic [31:0] ex_busB;
  logic [2:0]  ex_ALUctr;
  logic [31:0] ex_stdata;
  logic [4:0]  ex_dst;
  logic        ex_regwr;
  logic        ex_memwr;
  logic        ex_memtoreg;
  logic        ex_branch;
  logic        ex_illegal;
  logic        load_use;

  modport master (
    output stall, flush, id_valid, id_op, id_funct, id_rs, id_rt, id_rd,
           id_imm16, id_busA, id_busB, exf_regwr, exf_rd, exf_data,
           memf_regwr, memf_rd, memf_data,
    input  ex_valid, ex_busA, ex_busB, ex_ALUctr, ex_stdata, ex_dst,
           ex_regwr, ex_memwr, ex_memtoreg, ex_branch, ex_illegal, load_use
  );

  modport slave (
    input  stall, flush, id_valid, id_op, id_funct, id_rs, id_rt, id_rd,
           id_imm16, id_busA, id_busB, exf_regwr, exf_rd, exf_data,
           memf_regwr, memf_rd, memf_data,
    output ex_valid, ex_busA, ex_busB, ex_ALUctr, ex_stdata, ex_dst,
           ex_regwr, ex_memwr, ex_memtoreg, ex_branch, ex_illegal, load_use
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ID instruction, forwards operands from
// EX/MEM, detects load-use hazards, and captures bubbles on flush/hazard.
module id_ex_stage (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_LESS = 3'b111;

  typedef struct packed {
    logic        valid;
    logic [31:0] busa;
    logic [31:0] busb;
    logic [2:0]  aluctr;
    logic [31:0] stdata;
    logic [4:0]  dst;
    logic        regwr;
    logic        memwr;
    logic        memtoreg;
    logic        branch;
    logic        illegal;
  } ex_pkt_t;

  localparam ex_pkt_t BUBBLE = '{valid: 1'b0, busa: 32'd0, busb: 32'd0,
    aluctr: ALU_ADD, stdata: 32'd0, dst: 5'd0, regwr: 1'b0, memwr: 1'b0,
    memtoreg: 1'b0, branch: 1'b0, illegal: 1'b0};
  localparam ex_pkt_t ILLEGAL = '{valid: 1'b0, busa: 32'd0, busb: 32'd0,
    aluctr: ALU_ADD, stdata: 32'd0, dst: 5'd0, regwr: 1'b0, memwr: 1'b0,
    memtoreg: 1'b0, branch: 1'b0, illegal: 1'b1};

  // Register 0 is hard-wired, so it never takes a forwarded value.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  src,
    input logic [31:0] regval,
    input logic        ex_we,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_data,
    input logic        mem_we,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_data
  );
    logic [31:0] val;
    if ((src != 5'd0) && ex_we && (ex_rd == src)) begin
      val = ex_data;
    end else if ((src != 5'd0) && mem_we && (mem_rd == src)) begin
      val = mem_data;
    end else begin
      val = regval;
    end
    return val;
  endfunction

  ex_pkt_t     ex_r;
  ex_pkt_t     ex_nxt_s;
  ex_pkt_t     dec_s;
  logic [31:0] fwd_a_s;
  logic [31:0] fwd_b_s;
  logic [31:0] imm_sext_s;
  logic [31:0] imm_zext_s;
  logic        legal_s;
  logic        uses_rt_s;
  logic        load_use_s;

  // Operand forwarding and instruction decode.
  always_comb begin
    fwd_a_s    = fwd_sel(bus.id_rs, bus.id_busA, bus.exf_regwr, bus.exf_rd,
                         bus.exf_data, bus.memf_regwr, bus.memf_rd, bus.memf_data);
    fwd_b_s    = fwd_sel(bus.id_rt, bus.id_busB, bus.exf_regwr, bus.exf_rd,
                         bus.exf_data, bus.memf_regwr, bus.memf_rd, bus.memf_data);
    imm_sext_s = {{16{bus.id_imm16[15]}}, bus.id_imm16};
    imm_zext_s = {16'd0, bus.id_imm16};
    legal_s    = 1'b1;
    dec_s      = BUBBLE;
    dec_s.valid = 1'b1;
    dec_s.busa  = fwd_a_s;
    case (bus.id_op)
      OP_RTYPE: begin
        dec_s.busb  = fwd_b_s;
        dec_s.dst   = bus.id_rd;
        dec_s.regwr = 1'b1;
        case (bus.id_funct)
          FN_ADD:  dec_s.aluctr = ALU_ADD;
          FN_SUB:  dec_s.aluctr = ALU_SUB;
          FN_AND:  dec_s.aluctr = ALU_AND;
          FN_OR:   dec_s.aluctr = ALU_OR;
          FN_SLT:  dec_s.aluctr = ALU_LESS;
          default: legal_s      = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        dec_s.busb  = imm_sext_s;
        dec_s.dst   = bus.id_rt;
        dec_s.regwr = 1'b1;
      end
      OP_ORI: begin
        dec_s.busb   = imm_zext_s;
        dec_s.aluctr = ALU_OR;
        dec_s.dst    = bus.id_rt;
        dec_s.regwr  = 1'b1;
      end
      OP_LW: begin
        dec_s.busb     = imm_sext_s;
        dec_s.dst      = bus.id_rt;
        dec_s.regwr    = 1'b1;
        dec_s.memtoreg = 1'b1;
      end
      OP_SW: begin
        dec_s.busb   = imm_sext_s;
        dec_s.stdata = fwd_b_s;
        dec_s.memwr  = 1'b1;
      end
      OP_BEQ: begin
        dec_s.busb   = fwd_b_s;
        dec_s.aluctr = ALU_SUB;
        dec_s.branch = 1'b1;
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Load-use hazard against the load currently held in EX.
  always_comb begin
    uses_rt_s  = (bus.id_op == OP_RTYPE) || (bus.id_op == OP_BEQ) || (bus.id_op == OP_SW);
    load_use_s = ex_r.valid && ex_r.memtoreg && (ex_r.dst != 5'd0) && bus.id_valid &&
                 ((ex_r.dst == bus.id_rs) || (uses_rt_s && (ex_r.dst == bus.id_rt)));
  end

  // Next stage contents: flush beats stall beats hazard beats capture.
  always_comb begin
    ex_nxt_s = BUBBLE;
    if (bus.flush) begin
      ex_nxt_s = BUBBLE;
    end else if (bus.stall) begin
      ex_nxt_s = ex_r;
    end else if (load_use_s) begin
      ex_nxt_s = BUBBLE;
    end else if (!bus.id_valid) begin
      ex_nxt_s = BUBBLE;
    end else if (!legal_s) begin
      ex_nxt_s = ILLEGAL;
    end else begin
      ex_nxt_s = dec_s;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r <= BUBBLE;
    end else begin
      ex_r <= ex_nxt_s;
    end
  end

  assign bus.ex_valid    = ex_r.valid;
  assign bus.ex_busA     = ex_r.busa;
  assign bus.ex_busB     = ex_r.busb;
  assign bus.ex_ALUctr   = ex_r.aluctr;
  assign bus.ex_stdata   = ex_r.stdata;
  assign bus.ex_dst      = ex_r.dst;
  assign bus.ex_regwr    = ex_r.regwr;
  assign bus.ex_memwr    = ex_r.memwr;
  assign bus.ex_memtoreg = ex_r.memtoreg;
  assign bus.ex_branch   = ex_r.branch;
  assign bus.ex_illegal  = ex_r.illegal;
  assign bus.load_use    = load_use_s;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, multi-cycle hazard/stall/reset
// sequences, then random traffic against an instruction-level reference model.
module tb_id_ex_stage;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if bus();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDIU = 6'b001001, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

  typedef struct packed {
    logic        stall, flush, id_valid;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] busa, busb;
    logic        exf_regwr;
    logic [4:0]  exf_rd;
    logic [31:0] exf_data;
    logic        memf_regwr;
    logic [4:0]  memf_rd;
    logic [31:0] memf_data;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] busa, busb;
    logic [2:0]  alu;
    logic [31:0] stdata;
    logic [4:0]  dst;
    logic        regwr, memwr, memtoreg, branch, illegal;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDIU, K_ORI, K_LW, K_SW, K_BEQ, K_BAD} kind_e;

  function automatic in_t mk_in(input logic [5:0] op, input logic [5:0] funct,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b);
    in_t v;
    v = '0;
    v.id_valid = 1'b1;
    v.op = op; v.funct = funct; v.rs = rs; v.rt = rt; v.rd = rd;
    v.imm = imm; v.busa = a; v.busb = b;
    return v;
  endfunction

  function automatic exp_t mk_exp(input logic valid, input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] alu, input logic [31:0] std, input logic [4:0] dst,
                                  input logic rw, input logic mw, input logic mtr,
                                  input logic br, input logic ill);
    exp_t e;
    e.valid = valid; e.busa = a; e.busb = b; e.alu = alu; e.stdata = std; e.dst = dst;
    e.regwr = rw; e.memwr = mw; e.memtoreg = mtr; e.branch = br; e.illegal = ill;
    return e;
  endfunction

  function automatic exp_t bubble_e();
    return mk_exp(1'b0, 32'd0, 32'd0, 3'b010, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // ---------------- reference model ----------------
  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] funct);
    if (op == OP_R) begin
      if (funct == F_ADD) return K_ADD;
      if (funct == F_SUB) return K_SUB;
      if (funct == F_AND) return K_AND;
      if (funct == F_OR)  return K_OR;
      if (funct == F_SLT) return K_SLT;
      return K_BAD;
    end
    if (op == OP_ADDIU) return K_ADDIU;
    if (op == OP_ORI)   return K_ORI;
    if (op == OP_LW)    return K_LW;
    if (op == OP_SW)    return K_SW;
    if (op == OP_BEQ)   return K_BEQ;
    return K_BAD;
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] r, input logic [31:0] regval, input in_t v);
    if (r == 5'd0) return regval;
    if (v.exf_regwr && v.exf_rd == r) return v.exf_data;
    if (v.memf_regwr && v.memf_rd == r) return v.memf_data;
    return regval;
  endfunction

  function automatic exp_t model_decode(input in_t v);
    exp_t        e;
    kind_e       k;
    logic [31:0] rtv, sx, zx;
    k   = classify(v.op, v.funct);
    e   = bubble_e();
    if (k == K_BAD) begin
      e.illegal = 1'b1;
      return e;
    end
    rtv = src_val(v.rt, v.busb, v);
    sx  = 32'($signed(v.imm));
    zx  = {16'd0, v.imm};
    e.valid = 1'b1;
    e.busa  = src_val(v.rs, v.busa, v);
    case (k)
      K_ADD:   begin e.alu = 3'b010; e.busb = rtv; e.dst = v.rd; e.regwr = 1'b1; end
      K_SUB:   begin e.alu = 3'b110; e.busb = rtv; e.dst = v.rd; e.regwr = 1'b1; end
      K_AND:   begin e.alu = 3'b000; e.busb = rtv; e.dst = v.rd; e.regwr = 1'b1; end
      K_OR:    begin e.alu = 3'b001; e.busb = rtv; e.dst = v.rd; e.regwr = 1'b1; end
      K_SLT:   begin e.alu = 3'b111; e.busb = rtv; e.dst = v.rd; e.regwr = 1'b1; end
      K_ADDIU: begin e.alu = 3'b010; e.busb = sx; e.dst = v.rt; e.regwr = 1'b1; end
      K_ORI:   begin e.alu = 3'b001; e.busb = zx; e.dst = v.rt; e.regwr = 1'b1; end
      K_LW:    begin e.alu = 3'b010; e.busb = sx; e.dst = v.rt; e.regwr = 1'b1; e.memtoreg = 1'b1; end
      K_SW:    begin e.alu = 3'b010; e.busb = sx; e.stdata = rtv; e.memwr = 1'b1; end
      K_BEQ:   begin e.alu = 3'b110; e.busb = rtv; e.branch = 1'b1; end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic model_lu(input exp_t st, input in_t v);
    logic reads_rt;
    reads_rt = (v.op == OP_R) || (v.op == OP_BEQ) || (v.op == OP_SW);
    return st.valid && st.memtoreg && (st.dst != 5'd0) && v.id_valid &&
           ((st.dst == v.rs) || (reads_rt && st.dst == v.rt));
  endfunction

  function automatic exp_t model_next(input exp_t st, input in_t v);
    if (v.flush) return bubble_e();
    if (v.stall) return st;
    if (model_lu(st, v)) return bubble_e();
    if (!v.id_valid) return bubble_e();
    return model_decode(v);
  endfunction

  // ---------------- bench helpers ----------------
  task automatic drive(input in_t v);
    bus.stall = v.stall; bus.flush = v.flush; bus.id_valid = v.id_valid;
    bus.id_op = v.op; bus.id_funct = v.funct;
    bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_rd = v.rd;
    bus.id_imm16 = v.imm; bus.id_busA = v.busa; bus.id_busB = v.busb;
    bus.exf_regwr = v.exf_regwr; bus.exf_rd = v.exf_rd; bus.exf_data = v.exf_data;
    bus.memf_regwr = v.memf_regwr; bus.memf_rd = v.memf_rd; bus.memf_data = v.memf_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input exp_t e);
    chk({nm, ".valid"},    32'(bus.ex_valid),    32'(e.valid));
    chk({nm, ".busA"},     bus.ex_busA,          e.busa);
    chk({nm, ".busB"},     bus.ex_busB,          e.busb);
    chk({nm, ".ALUctr"},   32'(bus.ex_ALUctr),   32'(e.alu));
    chk({nm, ".stdata"},   bus.ex_stdata,        e.stdata);
    chk({nm, ".dst"},      32'(bus.ex_dst),      32'(e.dst));
    chk({nm, ".regwr"},    32'(bus.ex_regwr),    32'(e.regwr));
    chk({nm, ".memwr"},    32'(bus.ex_memwr),    32'(e.memwr));
    chk({nm, ".memtoreg"}, 32'(bus.ex_memtoreg), 32'(e.memtoreg));
    chk({nm, ".branch"},   32'(bus.ex_branch),   32'(e.branch));
    chk({nm, ".illegal"},  32'(bus.ex_illegal),  32'(e.illegal));
  endtask

  function automatic in_t rand_in();
    in_t        v;
    logic [5:0] ops [8];
    logic [5:0] fns [6];
    ops = '{OP_R, OP_R, OP_ADDIU, OP_ORI, OP_LW, OP_SW, OP_BEQ, 6'b111111};
    fns = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, 6'b000111};
    v.op         = ops[$urandom_range(0, 7)];
    if ($urandom_range(0, 15) == 0) v.op = 6'($urandom);
    v.funct      = fns[$urandom_range(0, 5)];
    v.rs         = 5'($urandom_range(0, 7));
    v.rt         = 5'($urandom_range(0, 7));
    v.rd         = 5'($urandom_range(0, 7));
    v.imm        = 16'($urandom);
    v.busa       = $urandom;
    v.busb       = $urandom;
    v.stall      = ($urandom_range(0, 9) == 0);
    v.flush      = ($urandom_range(0, 19) == 0);
    v.id_valid   = ($urandom_range(0, 7) != 0);
    v.exf_regwr  = 1'($urandom);
    v.exf_rd     = 5'($urandom_range(0, 7));
    v.exf_data   = $urandom;
    v.memf_regwr = 1'($urandom);
    v.memf_rd    = 5'($urandom_range(0, 7));
    v.memf_data  = $urandom;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    in_t  v;
    exp_t e_add, model;

    vecs[0].i  = mk_in(OP_R, F_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 32'd5, 32'd7);
    vecs[0].e  = mk_exp(1'b1, 32'd5, 32'd7, 3'b010, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1].i  = mk_in(OP_R, F_SUB, 5'd4, 5'd2, 5'd6, 16'd0, 32'h99, 32'h3);
    vecs[1].i.exf_regwr = 1'b1;  vecs[1].i.exf_rd = 5'd4;  vecs[1].i.exf_data = 32'h10;
    vecs[1].i.memf_regwr = 1'b1; vecs[1].i.memf_rd = 5'd4; vecs[1].i.memf_data = 32'h20;
    vecs[1].e  = mk_exp(1'b1, 32'h10, 32'h3, 3'b110, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[2].i  = mk_in(OP_R, F_SUB, 5'd0, 5'd0, 5'd7, 16'd0, 32'h55, 32'h66);
    vecs[2].i.exf_regwr = 1'b1;  vecs[2].i.exf_rd = 5'd0;  vecs[2].i.exf_data = 32'h10;
    vecs[2].i.memf_regwr = 1'b1; vecs[2].i.memf_rd = 5'd0; vecs[2].i.memf_data = 32'h20;
    vecs[2].e  = mk_exp(1'b1, 32'h55, 32'h66, 3'b110, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[3].i  = mk_in(OP_R, F_AND, 5'd8, 5'd9, 5'd10, 16'd0, 32'hF0, 32'h11);
    vecs[3].i.memf_regwr = 1'b1; vecs[3].i.memf_rd = 5'd9; vecs[3].i.memf_data = 32'hAB;
    vecs[3].i.exf_regwr = 1'b0;  vecs[3].i.exf_rd = 5'd9;  vecs[3].i.exf_data = 32'hCD;
    vecs[3].e  = mk_exp(1'b1, 32'hF0, 32'hAB, 3'b000, 32'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4].i  = mk_in(OP_R, F_OR, 5'd11, 5'd12, 5'd1, 16'd0, 32'h1, 32'h2);
    vecs[4].i.exf_regwr = 1'b1;  vecs[4].i.exf_rd = 5'd12;  vecs[4].i.exf_data = 32'hCAFE;
    vecs[4].i.memf_regwr = 1'b1; vecs[4].i.memf_rd = 5'd11; vecs[4].i.memf_data = 32'hD00D;
    vecs[4].e  = mk_exp(1'b1, 32'hD00D, 32'hCAFE, 3'b001, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[5].i  = mk_in(OP_R, F_SLT, 5'd1, 5'd2, 5'd31, 16'd0, 32'h3, 32'h4);
    vecs[5].e  = mk_exp(1'b1, 32'h3, 32'h4, 3'b111, 32'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[6].i  = mk_in(OP_ADDIU, 6'd0, 5'd1, 5'd12, 5'd0, 16'hFFFF, 32'h1, 32'h77);
    vecs[6].i.exf_regwr = 1'b1;  vecs[6].i.exf_rd = 5'd12;  vecs[6].i.exf_data = 32'h5555;
    vecs[6].e  = mk_exp(1'b1, 32'h1, 32'hFFFFFFFF, 3'b010, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[7].i  = mk_in(OP_ORI, 6'd0, 5'd2, 5'd3, 5'd0, 16'hFFFF, 32'h10, 32'h0);
    vecs[7].e  = mk_exp(1'b1, 32'h10, 32'h0000FFFF, 3'b001, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[8].i  = mk_in(OP_LW, 6'd0, 5'd2, 5'd13, 5'd0, 16'h0004, 32'h100, 32'h0);
    vecs[8].e  = mk_exp(1'b1, 32'h100, 32'h4, 3'b010, 32'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[9].i  = mk_in(OP_SW, 6'd0, 5'd3, 5'd14, 5'd0, 16'hFFF0, 32'h200, 32'h1234);
    vecs[9].i.exf_regwr = 1'b1;  vecs[9].i.exf_rd = 5'd14;  vecs[9].i.exf_data = 32'hBEEF;
    vecs[9].e  = mk_exp(1'b1, 32'h200, 32'hFFFFFFF0, 3'b010, 32'hBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[10].i = mk_in(OP_BEQ, 6'd0, 5'd5, 5'd6, 5'd0, 16'd0, 32'h9, 32'h9);
    vecs[10].i.memf_regwr = 1'b1; vecs[10].i.memf_rd = 5'd5; vecs[10].i.memf_data = 32'h42;
    vecs[10].e = mk_exp(1'b1, 32'h42, 32'h9, 3'b110, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[11].i = mk_in(6'b111111, 6'd0, 5'd1, 5'd2, 5'd3, 16'd0, 32'h1, 32'h2);
    vecs[11].e = mk_exp(1'b0, 32'd0, 32'd0, 3'b010, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[12].i = mk_in(OP_R, 6'b000000, 5'd1, 5'd2, 5'd3, 16'd0, 32'h1, 32'h2);
    vecs[12].e = mk_exp(1'b0, 32'd0, 32'd0, 3'b010, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[13].i = mk_in(OP_R, F_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 32'h1, 32'h2);
    vecs[13].i.id_valid = 1'b0;
    vecs[13].e = bubble_e();
    vecs[14].i = mk_in(OP_R, F_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 32'h1, 32'h2);
    vecs[14].i.flush = 1'b1;
    vecs[14].e = bubble_e();

    // reset state
    rst_n = 1'b0;
    v = mk_in(OP_R, F_ADD, 5'd0, 5'd0, 5'd0, 16'd0, 32'd0, 32'd0);
    v.id_valid = 1'b0;
    drive(v);
    #17;
    chk_out("reset", bubble_e());
    chk("reset.load_use", 32'(bus.load_use), 32'd0);
    rst_n = 1'b1;

    // directed vectors
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].i);
      #1;
      chk($sformatf("vec%0d.load_use", i), 32'(bus.load_use), 32'd0);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e);
    end

    // load-use: bubble, ID held, then capture with MEM forwarding
    drive(mk_in(OP_LW, 6'd0, 5'd1, 5'd5, 5'd0, 16'd0, 32'h40, 32'd0));
    tick();
    chk_out("lu.lw", mk_exp(1'b1, 32'h40, 32'd0, 3'b010, 32'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    v = mk_in(OP_R, F_ADD, 5'd5, 5'd2, 5'd6, 16'd0, 32'h1, 32'h2);
    drive(v);
    #1;
    chk("lu.hazard", 32'(bus.load_use), 32'd1);
    tick();
    chk_out("lu.bubble", bubble_e());
    v.memf_regwr = 1'b1; v.memf_rd = 5'd5; v.memf_data = 32'h777;
    drive(v);
    #1;
    chk("lu.cleared", 32'(bus.load_use), 32'd0);
    tick();
    chk_out("lu.add", mk_exp(1'b1, 32'h777, 32'h2, 3'b010, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(mk_in(OP_LW, 6'd0, 5'd1, 5'd7, 5'd0, 16'd0, 32'h3, 32'd0));
    tick();
    drive(mk_in(OP_ORI, 6'd0, 5'd1, 5'd7, 5'd0, 16'h0001, 32'h3, 32'd0));
    #1;
    chk("lu.ori_rt", 32'(bus.load_use), 32'd0);
    tick();
    chk_out("lu.ori", mk_exp(1'b1, 32'h3, 32'h1, 3'b001, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(mk_in(OP_LW, 6'd0, 5'd1, 5'd0, 5'd0, 16'd0, 32'h3, 32'd0));
    tick();
    drive(mk_in(OP_R, F_ADD, 5'd0, 5'd0, 5'd2, 16'd0, 32'h0, 32'h0));
    #1;
    chk("lu.r0", 32'(bus.load_use), 32'd0);

    // stall and flush together, then a three-cycle hold
    e_add = mk_exp(1'b1, 32'h11, 32'h22, 3'b010, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    v = mk_in(OP_R, F_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 32'h11, 32'h22);
    drive(v);
    tick();
    chk_out("sf.add", e_add);
    v.stall = 1'b1; v.flush = 1'b1;
    drive(v);
    tick();
    chk_out("sf.bubble", bubble_e());
    v.stall = 1'b0; v.flush = 1'b0;
    drive(v);
    tick();
    for (int k = 0; k < 3; k++) begin
      v = mk_in(OP_R, F_SUB, 5'd1, 5'd2, 5'd9, 16'd0, 32'(k + 100), 32'(k + 200));
      v.stall = 1'b1; v.exf_regwr = 1'b1; v.exf_rd = 5'd1; v.exf_data = 32'hEEEE;
      drive(v);
      tick();
      chk_out($sformatf("stall%0d", k), e_add);
    end

    // asynchronous reset between edges, then mid-stall
    v = mk_in(OP_R, F_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 32'h11, 32'h22);
    drive(v);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk_out("arst", bubble_e());
    rst_n = 1'b1;
    v = mk_in(OP_R, F_SUB, 5'd1, 5'd2, 5'd4, 16'd0, 32'h8, 32'h3);
    drive(v);
    tick();
    chk_out("arst.resume", mk_exp(1'b1, 32'h8, 32'h3, 3'b110, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    v.stall = 1'b1;
    drive(v);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    chk_out("arst.stall", bubble_e());

    // random traffic against the reference model
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model = bubble_e();
    for (int n = 0; n < 600; n++) begin
      v = rand_in();
      drive(v);
      #1;
      chk($sformatf("rnd%0d.load_use", n), 32'(bus.load_use), 32'(model_lu(model, v)));
      model = model_next(model, v);
      tick();
      chk_out($sformatf("rnd%0d", n), model);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
